pump_seq_ctrl: RTL and testbench

PUMP_SEQ_CTRL -- requirements
Module: pump_seq_ctrl

---
 rtl/pump_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_pump_seq_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pump_seq_ctrl.sv
// rtl/pump_seq_ctrl.sv - multi-channel 3-valve peristaltic pump phase sequencer
module pump_seq_ctrl #(
    parameter int NUM_PUMPS = 4,
    parameter int PHASE_W   = 16,
    parameter int STROKE_W  = 16,
    localparam int PUMP_W   = (NUM_PUMPS > 1) ? $clog2(NUM_PUMPS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [PUMP_W-1:0]    cmd_pump,
    input  logic                 cmd_dir,
    input  logic [STROKE_W-1:0]  cmd_strokes,
    input  logic [PHASE_W-1:0]   cmd_phase,
    input  logic [NUM_PUMPS-1:0] abort,
    output logic [NUM_PUMPS-1:0] out_air_valve1,
    output logic [NUM_PUMPS-1:0] out_air_dc,
    output logic [NUM_PUMPS-1:0] out_air_valve2,
    output logic [NUM_PUMPS-1:0] busy,
    output logic [NUM_PUMPS-1:0] done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    logic [NUM_PUMPS-1:0] ready_vec;

    // At most one channel matches cmd_pump, so the OR is that channel's readiness;
    // an out-of-range index matches nothing and leaves cmd_ready low.
    assign cmd_ready = |ready_vec;

    for (genvar g = 0; g < NUM_PUMPS; g++) begin : g_ch
        state_e                state_q,   state_d;
        logic                  dir_q,     dir_d;
        logic [STROKE_W-1:0]   strokes_q, strokes_d;
        logic [PHASE_W-1:0]    plen_q,    plen_d;
        logic [PHASE_W-1:0]    pcnt_q,    pcnt_d;
        logic [2:0]            step_q,    step_d;
        logic                  done_q,    done_d;
        logic                  sel;
        logic                  accept;
        logic [2:0]            phase_idx;
        logic [2:0]            valves;

        assign sel          = (cmd_pump == PUMP_W'(g));
        assign ready_vec[g] = sel && (state_q == IDLE) && !abort[g];
        assign accept       = cmd_valid && ready_vec[g];

        // State register: reset drops every channel to IDLE with counters cleared.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= IDLE;
                dir_q     <= 1'b0;
                strokes_q <= '0;
                plen_q    <= '0;
                pcnt_q    <= '0;
                step_q    <= '0;
                done_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                dir_q     <= dir_d;
                strokes_q <= strokes_d;
                plen_q    <= plen_d;
                pcnt_q    <= pcnt_d;
                step_q    <= step_d;
                done_q    <= done_d;
            end
        end

        // Next state: abort wins, then phase/stroke sequencing, then command accept.
        always_comb begin
            state_d   = state_q;
            dir_d     = dir_q;
            strokes_d = strokes_q;
            plen_d    = plen_q;
            pcnt_d    = pcnt_q;
            step_d    = step_q;
            done_d    = 1'b0;
            if (abort[g]) begin
                state_d = IDLE;
            end else if (state_q == RUN) begin
                if (pcnt_q == plen_q - PHASE_W'(1)) begin
                    pcnt_d = '0;
                    if (step_q == 3'd5) begin
                        step_d = 3'd0;
                        if (strokes_q == STROKE_W'(1)) begin
                            state_d   = IDLE;
                            strokes_d = '0;
                            done_d    = 1'b1;
                        end else begin
                            strokes_d = strokes_q - STROKE_W'(1);
                        end
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end else begin
                    pcnt_d = pcnt_q + PHASE_W'(1);
                end
            end else if (accept) begin
                dir_d     = cmd_dir;
                strokes_d = cmd_strokes;
                plen_d    = (cmd_phase == '0) ? PHASE_W'(1) : cmd_phase;
                pcnt_d    = '0;
                step_d    = 3'd0;
                if (cmd_strokes == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
        end

        // Outputs: step counts in run order; reverse walks the same table backwards.
        always_comb begin
            phase_idx = dir_q ? (3'd5 - step_q) : step_q;
            valves    = 3'b111;
            if (state_q == RUN) begin
                case (phase_idx)
                    3'd0:    valves = 3'b100;
                    3'd1:    valves = 3'b110;
                    3'd2:    valves = 3'b010;
                    3'd3:    valves = 3'b011;
                    3'd4:    valves = 3'b001;
                    3'd5:    valves = 3'b101;
                    default: valves = 3'b111;
                endcase
            end
        end

        assign out_air_valve1[g] = valves[2];
        assign out_air_dc[g]     = valves[1];
        assign out_air_valve2[g] = valves[0];
        assign busy[g]           = (state_q == RUN);
        assign done[g]           = done_q;
    end

endmodule

// File: tb/tb_pump_seq_ctrl.sv
// tb/tb_pump_seq_ctrl.sv - randomized and directed bench for pump_seq_ctrl against a timeline model
module tb_pump_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_pump;
    logic        cmd_dir;
    logic [15:0] cmd_strokes;
    logic [15:0] cmd_phase;
    logic [3:0]  abort;
    logic [3:0]  out_air_valve1;
    logic [3:0]  out_air_dc;
    logic [3:0]  out_air_valve2;
    logic [3:0]  busy;
    logic [3:0]  done;

    always #5 clk = ~clk;

    pump_seq_ctrl #(.NUM_PUMPS(4), .PHASE_W(16), .STROKE_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_pump       (cmd_pump),
        .cmd_dir        (cmd_dir),
        .cmd_strokes    (cmd_strokes),
        .cmd_phase      (cmd_phase),
        .abort          (abort),
        .out_air_valve1 (out_air_valve1),
        .out_air_dc     (out_air_dc),
        .out_air_valve2 (out_air_valve2),
        .busy           (busy),
        .done           (done)
    );

    int     errors = 0;
    int     checks = 0;
    longint cyc    = 0;
    int     done1001_cnt = 0;

    // Model: each channel remembers when its command was accepted and how long
    // the run lasts; everything visible is derived from elapsed time.
    logic       act [4];
    longint     st  [4];
    longint     tot [4];
    logic       dr  [4];
    longint     pl  [4];
    logic [2:0] pat [6];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input int p, input logic d,
                        input int s, input int ph, input logic [3:0] ab);
        logic [3:0] be, de, v1e, dce, v2e;
        logic       re;
        longint     e, k;
        int         idx;
        rst         = r;
        cmd_valid   = v;
        cmd_pump    = p[1:0];
        cmd_dir     = d;
        cmd_strokes = s[15:0];
        cmd_phase   = ph[15:0];
        abort       = ab;
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            be[ch] = 1'b0; de[ch] = 1'b0;
            v1e[ch] = 1'b1; dce[ch] = 1'b1; v2e[ch] = 1'b1;
            if (act[ch]) begin
                e = cyc - st[ch] - 1;
                if (e >= 0 && e < tot[ch]) begin
                    be[ch] = 1'b1;
                    k   = (e / pl[ch]) % 6;
                    idx = dr[ch] ? 5 - int'(k) : int'(k);
                    v1e[ch] = pat[idx][2];
                    dce[ch] = pat[idx][1];
                    v2e[ch] = pat[idx][0];
                end else if (e == tot[ch]) begin
                    de[ch] = 1'b1;
                end
            end
        end
        re = !be[p] && !ab[p];
        check_eq("cmd_ready", {31'd0, cmd_ready}, {31'd0, re});
        check_eq("busy",   {28'd0, busy},           {28'd0, be});
        check_eq("done",   {28'd0, done},           {28'd0, de});
        check_eq("valve1", {28'd0, out_air_valve1}, {28'd0, v1e});
        check_eq("dc",     {28'd0, out_air_dc},     {28'd0, dce});
        check_eq("valve2", {28'd0, out_air_valve2}, {28'd0, v2e});
        if (done === 4'b1001) done1001_cnt++;
        @(posedge clk);
        if (r) begin
            for (int ch = 0; ch < 4; ch++) act[ch] = 1'b0;
        end else begin
            for (int ch = 0; ch < 4; ch++)
                if (ab[ch] && be[ch]) act[ch] = 1'b0;
            if (v && re) begin
                act[p] = 1'b1;
                st[p]  = cyc;
                pl[p]  = (ph == 0) ? 1 : longint'(ph);
                tot[p] = longint'(s) * 6 * pl[p];
                dr[p]  = d;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 0, 0, 4'b0000);
    endtask

    initial begin
        pat[0] = 3'b100; pat[1] = 3'b110; pat[2] = 3'b010;
        pat[3] = 3'b011; pat[4] = 3'b001; pat[5] = 3'b101;
        for (int ch = 0; ch < 4; ch++) begin
            act[ch] = 1'b0; st[ch] = 0; tot[ch] = 0; dr[ch] = 1'b0; pl[ch] = 1;
        end
        rst = 1'b1; cmd_valid = 1'b0; cmd_pump = '0; cmd_dir = 1'b0;
        cmd_strokes = '0; cmd_phase = '0; abort = '0;
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 1'b0, 0, 1'b0, 0, 0, 4'b0000);
        idle(2);

        // ch0 forward 2 strokes x 3 cycles; busy ch0 refuses a command; ch2 zero strokes; ch1 reverse phase 0
        step(1'b0, 1'b1, 0, 1'b0, 2, 3, 4'b0000);
        idle(4);
        step(1'b0, 1'b1, 0, 1'b1, 5, 5, 4'b0000);
        step(1'b0, 1'b1, 2, 1'b0, 0, 7, 4'b0000);
        step(1'b0, 1'b1, 1, 1'b1, 1, 0, 4'b0000);
        idle(40);

        // abort during S3 of the first stroke
        step(1'b0, 1'b1, 0, 1'b0, 2, 2, 4'b0000);
        idle(4);
        step(1'b0, 1'b0, 0, 1'b0, 0, 0, 4'b0001);
        idle(2);

        // abort on the final RUN cycle suppresses done
        step(1'b0, 1'b1, 1, 1'b0, 1, 1, 4'b0000);
        idle(5);
        step(1'b0, 1'b0, 0, 1'b0, 0, 0, 4'b0010);
        idle(3);

        // ch0 and ch3 finish on the same cycle
        step(1'b0, 1'b1, 0, 1'b0, 2, 1, 4'b0000);
        idle(5);
        step(1'b0, 1'b1, 3, 1'b1, 1, 1, 4'b0000);
        idle(10);
        check_eq("done_1001_pulses", done1001_cnt, 1);

        // maximum strokes and phase accepted, then aborted
        step(1'b0, 1'b1, 2, 1'b0, 16'hFFFF, 16'hFFFF, 4'b0000);
        step(1'b0, 1'b1, 3, 1'b1, 16'hFFFF, 1, 4'b0000);
        idle(20);
        step(1'b0, 1'b0, 0, 1'b0, 0, 0, 4'b1100);
        idle(2);

        // reset in the middle of four running channels, then immediate new command
        for (int ch = 0; ch < 4; ch++) step(1'b0, 1'b1, ch, ch[0], 3, 2, 4'b0000);
        idle(3);
        step(1'b1, 1'b0, 0, 1'b0, 0, 0, 4'b0000);
        step(1'b0, 1'b1, 2, 1'b0, 1, 1, 4'b0000);
        idle(8);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] ab;
            for (int b = 0; b < 4; b++) ab[b] = ($urandom % 40) == 0;
            step(($urandom % 400) == 0, ($urandom % 3) == 0, int'($urandom % 4),
                 1'($urandom % 2), int'($urandom % 4), int'($urandom % 4), ab);
        end
        idle(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
